avalon_bus_arbiter: RTL and testbench
=====================================

// Module: avalon_bus_arbiter
// PURPOSE
// - Two-master / one-slave Avalon-MM arbiter in front of the shared RAM.
// - Master 0 (m0_*) is the program loader / debug port; master 1 (m1_*) is top_level_CPU.
// - Registered grant FSM. Holds a grant until the slave completes the transfer
//   (waitrequest low). Stalls the losing master by driving its waitrequest high.
// PARAMETERS
// - ADDR_W  32  address width of both masters and the slave
// - DATA_W  32  data width; byteenable width is DATA_W/8
// PORTS
// - clk             in   1         system clock, all state on rising edge
// - reset           in   1         synchronous, active-high
// - m0_address      in   ADDR_W    loader address
// - m0_read         in   1         loader read request
// - m0_write        in   1         loader write request
// - m0_writedata    in   DATA_W    loader write data
// - m0_byteenable   in   DATA_W/8  loader byte lanes
// - m0_waitrequest  out  1         loader stall
// - m0_readdata     out  DATA_W    loader read data
// - m1_*            same set as m0_*, for the CPU master
// - s_address       out  ADDR_W    to RAM
// - s_read          out  1         to RAM
// - s_write         out  1         to RAM
// - s_writedata     out  DATA_W    to RAM
// - s_byteenable    out  DATA_W/8  to RAM
// - s_waitrequest   in   1         from RAM
// - s_readdata      in   DATA_W    from RAM
// - grant           out  2         one-hot current owner: 01=m0, 10=m1, 00=idle
// BEHAVIOUR
// - Request: mN_req = mN_read | mN_write. read and write both high is a protocol error: treat as a read.
// - States: IDLE, GNT0, GNT1. State is registered. All outputs decode combinationally from state.
// - Reset: state IDLE; grant=00; s_read=s_write=0; s_address/s_writedata=0; s_byteenable=0;
//   m0/m1_waitrequest=1.
// - IDLE: slave strobes 0 and both waitrequests 1.
//   - Only m0_req -> GNT0. Only m1_req -> GNT1. Neither -> stay IDLE.
//   - Both requesting -> winner per arbitration policy (CONFIGURATION).
// - GNTn: s_* = mn_* (mux). mn_waitrequest = s_waitrequest. Other master's waitrequest = 1.
//   - Complete when mn_req=1 and s_waitrequest=0 in the same cycle. Next state IDLE.
//   - s_waitrequest=1 -> stay GNTn. The other master's requests are ignored (no preemption).
//   - mn_req drops before completion (abandon) -> slave strobes 0 that cycle. Next state IDLE.
// - Latency: one arbitration cycle (IDLE) plus >=1 granted cycle.
//   - Zero-wait slave: a transfer completes in the 2nd cycle of the request.
//   - Back-to-back requests from one master: a 2-cycle minimum per transfer.
// - m0_readdata = m1_readdata = s_readdata (broadcast). Valid only for the granted master
//   while its waitrequest=0.
// - Reset asserted mid-transfer: next edge goes to IDLE and strobes drop. The in-flight transfer is lost.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined: 1-bit last-owner register, reset value 1 (so m0 wins first).
//   - On a simultaneous request in IDLE, grant the master not served last.
//   - The register updates on every completion.
// - Not defined: fixed priority. m0 wins every tie; the register is absent.
// TESTING
// - Reset mid-GNT1 write (s_waitrequest held 1) -> next cycle grant=00, s_write=0,
//   both waitrequests 1.
// - m1 read 0x00000004, RAM zero-wait, data 0x24032468 -> grant=10 on cycle 2;
//   m1_waitrequest low on cycle 2; m1_readdata=0x24032468.
// - m0 write 0x0000000C, data 0x00000008, be=1111, RAM waitrequest 3 cycles
//   -> grant=01 held 4 cycles; RAM word 0x0C = 0x00000008.
//   - An m1 read raised during this transfer stays stalled until m0 completes.
// - Both request every cycle:
//   - Without ARB_ROUND_ROBIN_EN: m0 always wins and m1 is starved.
//   - With it: grants alternate 01,10,01,10.
// - m1 drops read after 1 stalled cycle -> s_read=0 that cycle; IDLE next; no RAM access.
// - CPU andi program (0x24032468, 0x3062FFFF, 0x00000008) loaded via m0, run via m1
//   -> register_v0 = 0x00002468 at active falling edge.

Source files
------------

// File: rtl/avalon_bus_arbiter_if.sv
// Avalon-MM bus bundle shared by both masters and the RAM slave of avalon_bus_arbiter.
// The master modport is the side that issues transfers; the slave modport answers them.
interface avalon_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter with a registered IDLE/GNT0/GNT1 grant FSM.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 wins every tie.
module avalon_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    avalon_bus_arbiter_if.slave  m0,
    avalon_bus_arbiter_if.slave  m1,
    avalon_bus_arbiter_if.master s,
    output logic [1:0]           grant
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;

    logic m0_req;
    logic m1_req;
    logic tie_to_m1;

    logic [ADDR_W-1:0] sel_address;
    logic              sel_read;
    logic              sel_write;
    logic [DATA_W-1:0] sel_writedata;
    logic [BE_W-1:0]   sel_byteenable;
    logic              m0_wait;
    logic              m1_wait;

    assign m0_req = m0.read | m0.write;
    assign m1_req = m1.read | m1.write;

`ifdef ARB_ROUND_ROBIN_EN
    // last_owner = 1 means m1 was served last, so m0 wins the next tie.
    logic last_owner;
    assign tie_to_m1 = ~last_owner;
`else
    assign tie_to_m1 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        state <= tie_to_m1 ? GNT1 : GNT0;
                    end else if (m0_req) begin
                        state <= GNT0;
                    end else if (m1_req) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (!m0_req || !s.waitrequest) begin
                        state <= IDLE;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    if (m0_req && !s.waitrequest) begin
                        last_owner <= 1'b0;
                    end
`endif
                end
                GNT1: begin
                    if (!m1_req || !s.waitrequest) begin
                        state <= IDLE;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    if (m1_req && !s.waitrequest) begin
                        last_owner <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A master raising read and write together is served as a plain read.
    always_comb begin
        grant          = 2'b00;
        sel_address    = '0;
        sel_read       = 1'b0;
        sel_write      = 1'b0;
        sel_writedata  = '0;
        sel_byteenable = '0;
        m0_wait        = 1'b1;
        m1_wait        = 1'b1;
        case (state)
            GNT0: begin
                grant          = 2'b01;
                sel_address    = m0.address;
                sel_read       = m0.read;
                sel_write      = m0.write & ~m0.read;
                sel_writedata  = m0.writedata;
                sel_byteenable = m0.byteenable;
                m0_wait        = s.waitrequest;
            end
            GNT1: begin
                grant          = 2'b10;
                sel_address    = m1.address;
                sel_read       = m1.read;
                sel_write      = m1.write & ~m1.read;
                sel_writedata  = m1.writedata;
                sel_byteenable = m1.byteenable;
                m1_wait        = s.waitrequest;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

    assign s.address    = sel_address;
    assign s.read       = sel_read;
    assign s.write      = sel_write;
    assign s.writedata  = sel_writedata;
    assign s.byteenable = sel_byteenable;

    assign m0.waitrequest = m0_wait;
    assign m1.waitrequest = m1_wait;
    assign m0.readdata    = s.readdata;
    assign m1.readdata    = s.readdata;
endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: directed arbitration scenarios plus randomized traffic
// from both masters into a behavioural RAM, checked by a scoreboard monitor.
module tb_avalon_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant;

    always #5 clk = ~clk;

    avalon_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
    avalon_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
    avalon_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

    avalon_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .grant (grant)
    );

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    txn_t        exp_q0[$];
    txn_t        exp_q1[$];
    logic [31:0] model_mem [64];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mon_en   = 1'b0;

    // Behavioural RAM: fixed or random wait states, byte-lane writes, combinational read data.
    logic [31:0] ram [64];
    int          wait_cnt     = 0;
    int          rand_wait    = 0;
    int          ram_accesses = 0;
    int          fixed_wait   = 0;
    bit          rand_mode    = 1'b0;
    int          cur_wait;

    assign cur_wait = rand_mode ? rand_wait : fixed_wait;

    always_comb s_bus.waitrequest = (s_bus.read || s_bus.write) && (wait_cnt < cur_wait);
    always_comb s_bus.readdata    = ram[s_bus.address[7:2]];

    always @(posedge clk) begin
        if (s_bus.read || s_bus.write) begin
            if (s_bus.waitrequest) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                wait_cnt     <= 0;
                ram_accesses <= ram_accesses + 1;
                rand_wait    <= $urandom_range(0, 2);
                if (s_bus.write) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_bus.byteenable[b]) ram[s_bus.address[7:2]][8*b +: 8] <= s_bus.writedata[8*b +: 8];
                    end
                end
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic wait_of(input int n);
        return (n == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
    endfunction

    task automatic drive(input int n, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        if (n == 0) begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = addr;
            m0_bus.writedata = data; m0_bus.byteenable = be;
        end else begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = addr;
            m1_bus.writedata = data; m1_bus.byteenable = be;
        end
    endtask

    task automatic idle_master(input int n);
        drive(n, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a flat word memory; a read returns the last value written, a
    // read+write request counts as a read and leaves memory untouched.
    task automatic push_expected(input int n, input bit rd, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] be);
        txn_t t;
        int   idx;
        idx    = int'(addr[7:2]);
        t.rd   = rd;
        t.addr = addr;
        t.be   = be;
        if (rd) begin
            t.data = model_mem[idx];
        end else begin
            t.data = data;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
        if (n == 0) exp_q0.push_back(t);
        else exp_q1.push_back(t);
    endtask

    // Issue one transfer and hold it until accepted; leaves the request asserted.
    task automatic apply_stimulus(input int n, input bit rd, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [3:0] be);
        int cyc;
        push_expected(n, rd, addr, data, be);
        drive(n, rd, wr, addr, data, be);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!wait_of(n)) break;
            if (cyc >= 200) begin
                n_checks++;
                $display("[TB] FAIL xfer_timeout m%0d: still stalled after %0d cycles, expected completion", n, cyc);
                break;
            end
        end
        step();
    endtask

    task automatic check_completion(input int n);
        txn_t t;
        if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
            n_checks++;
            $display("[TB] FAIL unexpected_completion m%0d: got completion, expected none", n);
            return;
        end
        t = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check_output($sformatf("grant_m%0d", n), {30'd0, grant}, (n == 0) ? 32'h1 : 32'h2);
        if (t.rd) begin
            check_output($sformatf("readdata_m%0d", n), (n == 0) ? m0_bus.readdata : m1_bus.readdata, t.data);
            check_output($sformatf("s_write_on_read_m%0d", n), {31'd0, s_bus.write}, 32'h0);
        end else begin
            check_output($sformatf("s_write_m%0d", n), {31'd0, s_bus.write}, 32'h1);
            check_output($sformatf("s_address_m%0d", n), s_bus.address, t.addr);
            check_output($sformatf("s_writedata_m%0d", n), s_bus.writedata, t.data);
            check_output($sformatf("s_byteenable_m%0d", n), {28'd0, s_bus.byteenable}, {28'd0, t.be});
        end
    endtask

    task automatic random_master(input int n, input int base_word, input int count);
        int          gap;
        int          kind;
        logic [31:0] addr;
        for (int i = 0; i < count; i++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                idle_master(n);
                repeat (gap) step();
            end
            kind = $urandom_range(0, 7);
            addr = 32'((base_word + $urandom_range(0, 27)) * 4);
            apply_stimulus(n, kind <= 3, (kind == 0) || (kind >= 4), addr, $urandom, 4'($urandom_range(0, 15)));
        end
        idle_master(n);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          acc_before;
        int          wait_cnt_m1;
        logic [1:0]  tie_log[$];
        logic [1:0]  tie_exp [4];
        logic [31:0] word;

        reset = 1'b1;
        idle_master(0);
        idle_master(1);

        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if ((m0_bus.read || m0_bus.write) && !m0_bus.waitrequest) check_completion(0);
                    if ((m1_bus.read || m1_bus.write) && !m1_bus.waitrequest) check_completion(1);
                end
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_grant", {30'd0, grant}, 32'h0);
        check_output("rst_s_read", {31'd0, s_bus.read}, 32'h0);
        check_output("rst_s_write", {31'd0, s_bus.write}, 32'h0);
        check_output("rst_s_address", s_bus.address, 32'h0);
        check_output("rst_s_writedata", s_bus.writedata, 32'h0);
        check_output("rst_s_byteenable", {28'd0, s_bus.byteenable}, 32'h0);
        check_output("rst_m0_wait", {31'd0, m0_bus.waitrequest}, 32'h1);
        check_output("rst_m1_wait", {31'd0, m1_bus.waitrequest}, 32'h1);
        step();
        reset  = 1'b0;
        mon_en = 1'b1;

        // Loader fills the RAM through m0, program words at 0x4 and 0x8.
        for (int i = 0; i < 64; i++) begin
            word = (i == 1) ? 32'h24032468 : (i == 2) ? 32'h3062FFFF : (i == 3) ? 32'h0 : $urandom;
            apply_stimulus(0, 1'b0, 1'b1, 32'(i * 4), word, 4'hF);
        end
        idle_master(0);
        step();

        // m1 read of 0x4 from a zero-wait RAM.
        push_expected(1, 1'b1, 32'h4, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        @(negedge clk);
        check_output("rd4_c1_grant", {30'd0, grant}, 32'h0);
        check_output("rd4_c1_m1_wait", {31'd0, m1_bus.waitrequest}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        check_output("rd4_c2_grant", {30'd0, grant}, 32'h2);
        check_output("rd4_c2_m1_wait", {31'd0, m1_bus.waitrequest}, 32'h0);
        check_output("rd4_c2_readdata", m1_bus.readdata, 32'h24032468);
        step();
        idle_master(1);
        step();

        // m0 write with 3 RAM wait states while m1 asks for 0x8.
        fixed_wait = 3;
        push_expected(0, 1'b0, 32'hC, 32'h8, 4'hF);
        drive(0, 1'b0, 1'b1, 32'hC, 32'h8, 4'hF);
        @(negedge clk);
        check_output("wr_c1_grant", {30'd0, grant}, 32'h0);
        step();
        push_expected(1, 1'b1, 32'h8, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check_output($sformatf("wr_c%0d_grant", c), {30'd0, grant}, 32'h1);
            check_output($sformatf("wr_c%0d_m1_wait", c), {31'd0, m1_bus.waitrequest}, 32'h1);
            check_output($sformatf("wr_c%0d_m0_wait", c), {31'd0, m0_bus.waitrequest}, (c == 5) ? 32'h0 : 32'h1);
            @(posedge clk);
        end
        #1;
        idle_master(0);
        wait_cnt_m1 = 0;
        forever begin
            @(negedge clk);
            wait_cnt_m1++;
            if (!m1_bus.waitrequest) break;
            if (wait_cnt_m1 >= 50) begin
                n_checks++;
                $display("[TB] FAIL m1_after_m0_timeout: still stalled after %0d cycles, expected completion", wait_cnt_m1);
                break;
            end
        end
        step();
        idle_master(1);
        fixed_wait = 0;
        step();
        check_output("ram_word_0C", ram[3], 32'h8);
        apply_stimulus(1, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF);
        idle_master(1);
        step();

        // Reset in the middle of a stalled m1 write.
        mon_en     = 1'b0;
        fixed_wait = 1000;
        drive(1, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output("rstmid_pre_grant", {30'd0, grant}, 32'h2);
        check_output("rstmid_pre_s_write", {31'd0, s_bus.write}, 32'h1);
        step();
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output("rstmid_grant", {30'd0, grant}, 32'h0);
        check_output("rstmid_s_write", {31'd0, s_bus.write}, 32'h0);
        check_output("rstmid_m0_wait", {31'd0, m0_bus.waitrequest}, 32'h1);
        check_output("rstmid_m1_wait", {31'd0, m1_bus.waitrequest}, 32'h1);
        step();
        idle_master(1);
        step();
        reset = 1'b0;

        // Both masters request continuously from a freshly reset arbiter.
        fixed_wait = 0;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (grant != 2'b00) tie_log.push_back(grant);
            @(posedge clk);
        end
        #1;
        idle_master(0);
        idle_master(1);
`ifdef ARB_ROUND_ROBIN_EN
        tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        tie_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        check_output("tie_grant_count", 32'(tie_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("tie_grant_%0d", k), (k < tie_log.size()) ? {30'd0, tie_log[k]} : 32'hFFFFFFFF, {30'd0, tie_exp[k]});
        end
        step();
        step();

        // m1 abandons a stalled read.
        fixed_wait = 1000;
        acc_before = ram_accesses;
        drive(1, 1'b1, 1'b0, 32'h18, 32'h0, 4'hF);
        @(negedge clk);
        check_output("abandon_c1_grant", {30'd0, grant}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check_output("abandon_c2_grant", {30'd0, grant}, 32'h2);
        check_output("abandon_c2_s_read", {31'd0, s_bus.read}, 32'h1);
        check_output("abandon_c2_m1_wait", {31'd0, m1_bus.waitrequest}, 32'h1);
        step();
        idle_master(1);
        @(negedge clk);
        check_output("abandon_c3_s_read", {31'd0, s_bus.read}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check_output("abandon_c4_grant", {30'd0, grant}, 32'h0);
        check_output("abandon_ram_accesses", 32'(ram_accesses), 32'(acc_before));
        step();

        // Randomized traffic from both masters into disjoint RAM regions.
        fixed_wait = 0;
        rand_mode  = 1'b1;
        mon_en     = 1'b1;
        fork
            random_master(0, 8, 40);
            random_master(1, 36, 40);
        join
        step();
        step();
        check_output("scoreboard_q0_empty", 32'(exp_q0.size()), 32'd0);
        check_output("scoreboard_q1_empty", 32'(exp_q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
